imm_encoder: RTL

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder_pkg.sv | 81 ++++++++
 rtl/imm_encoder_range_chk.sv | 42 ++++
 rtl/imm_encoder.sv | 95 +++++++++
 3 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder and its matching decode side:
// select codes, error codes, format range limits and bit-placement helpers.
package imm_encoder_pkg;

    typedef enum logic [2:0] {
        SEL_I = 3'd0,
        SEL_S = 3'd1,
        SEL_B = 3'd2,
        SEL_U = 3'd3,
        SEL_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_ALIGN = 2'd2,
        ERR_SEL   = 2'd3
    } imm_err_e;

    localparam int signed I_MIN = -2048;
    localparam int signed I_MAX = 2047;
    localparam int signed B_MIN = -4096;
    localparam int signed B_MAX = 4094;
    localparam int signed J_MIN = -1048576;
    localparam int signed J_MAX = 1048574;

    // Instruction bits owned by the immediate of each format; zero for illegal selects.
    function automatic logic [31:0] imm_mask(input logic [2:0] sel);
        logic [31:0] m;
        case (sel)
            SEL_I:   m = 32'hFFF0_0000;
            SEL_S:   m = 32'hFE00_0F80;
            SEL_B:   m = 32'hFE00_0F80;
            SEL_U:   m = 32'hFFFF_F000;
            SEL_J:   m = 32'hFFFF_F000;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] imm_place(input logic [2:0] sel, input logic [31:0] imm);
        logic [31:0] w;
        w = '0;
        case (sel)
            SEL_I: w[31:20] = imm[11:0];
            SEL_S: begin
                w[31:25] = imm[11:5];
                w[11:7]  = imm[4:0];
            end
            SEL_B: begin
                w[31]    = imm[12];
                w[30:25] = imm[10:5];
                w[11:8]  = imm[4:1];
                w[7]     = imm[11];
            end
            SEL_U: w[31:12] = imm[31:12];
            SEL_J: begin
                w[31]    = imm[20];
                w[30:21] = imm[10:1];
                w[20]    = imm[11];
                w[19:12] = imm[19:12];
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic signed [31:0] imm_decode(input logic [31:0] inst, input logic [2:0] sel);
        logic signed [31:0] v;
        case (sel)
            SEL_I:   v = {{20{inst[31]}}, inst[31:20]};
            SEL_S:   v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            SEL_B:   v = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            SEL_U:   v = {inst[31:12], 12'b0};
            SEL_J:   v = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/imm_encoder_range_chk.sv
// Combinational range/alignment/select check for one immediate request.
module imm_range_chk
    import imm_encoder_pkg::*;
(
    input  logic        [2:0]  sel,
    input  logic signed [31:0] imm,
    output imm_err_e           err
);

    logic illegal;
    logic misaligned;
    logic out_of_range;

    always_comb begin
        illegal      = 1'b0;
        misaligned   = 1'b0;
        out_of_range = 1'b0;
        case (sel)
            SEL_I, SEL_S: out_of_range = (imm < I_MIN) || (imm > I_MAX);
            SEL_B: begin
                misaligned   = imm[0];
                out_of_range = (imm < B_MIN) || (imm > B_MAX);
            end
            SEL_U: out_of_range = (imm[11:0] != 12'd0);
            SEL_J: begin
                misaligned   = imm[0];
                out_of_range = (imm < J_MIN) || (imm > J_MAX);
            end
            default: illegal = 1'b1;
        endcase

        if (illegal)
            err = ERR_SEL;
        else if (misaligned)
            err = ERR_ALIGN;
        else if (out_of_range)
            err = ERR_RANGE;
        else
            err = ERR_NONE;
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: stage 1 holds the request and checks it,
// stage 2 holds the encoded word that drives the outputs.
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic        [2:0]  imm_sel,
    input  logic signed [31:0] imm,
    input  logic        [31:0] base_inst,
    output logic               out_valid,
    input  logic               out_ready,
    output logic        [31:0] out_inst,
    output logic        [1:0]  out_err,
    output logic        [15:0] err_cnt
);

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic               vld_p1;
    logic        [2:0]  sel_p1;
    logic signed [31:0] imm_p1;
    logic        [31:0] base_p1;

    logic               vld_p2;
    logic        [31:0] inst_p2;
    logic        [1:0]  err_p2;

    logic               load_p2;
    imm_err_e           err_chk;
    logic        [31:0] inst_enc;

    assign load_p2  = !vld_p2 || out_ready;
    assign in_ready = !rst && (!vld_p1 || load_p2);

    // ---- stage 1: capture request ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (in_ready)
            vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            sel_p1  <= imm_sel;
            imm_p1  <= imm;
            base_p1 <= base_inst;
        end
    end

    imm_range_chk u_chk (
        .sel (sel_p1),
        .imm (imm_p1),
        .err (err_chk)
    );

    // Error words keep the non-immediate fields but zero the immediate slots.
    always_comb begin
        inst_enc = base_p1 & ~imm_mask(sel_p1);
        if (err_chk == ERR_NONE)
            inst_enc = inst_enc | imm_place(sel_p1, imm_p1);
    end

    // ---- stage 2: output register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            inst_p2 <= '0;
            err_p2  <= '0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                inst_p2 <= inst_enc;
                err_p2  <= err_chk;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (vld_p2 && out_ready && (err_p2 != 2'd0))
            err_cnt <= sat_inc(err_cnt);
    end

    assign out_valid = vld_p2;
    assign out_inst  = inst_p2;
    assign out_err   = err_p2;

endmodule
